clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-keeping and time-setting controller for the digital clock. Owns the hour/minute/second registers, advances them on a 1 Hz enable, and sequences a user set mode driven by three debounced push-buttons. Produces per-field blink masks for the display path and the top-of-hour chime LED. Sits between the key inputs and the BCD split/display logic.

## Interface
- DEBOUNCE_CYC, 20000: consecutive clk cycles a synchronized key must differ from its debounced level before the level flips (≥2).
- TIMEOUT_S, 30: tick_1hz pulses without any key press before set mode auto-exits to RUN (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  single-cycle enable, once per second.
- tick_2hz  in  1  single-cycle enable, twice per second.
- key_mode  in  1  raw active-high button, asynchronous.
- key_inc  in  1  raw active-high button, asynchronous.
- key_dec  in  1  raw active-high button, asynchronous.
- hour  out  5  0–23.
- min  out  6  0–59.
- sec  out  6  0–59.
- mode  out  2  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
- blink_mask  out  3  [2] blank hour, [1] blank min, [0] blank sec.
- led_chime  out  1  chime LED.

## Operation
- Reset: hour=0, min=0, sec=0, mode=RUN, blink_mask=0, led_chime=0, blink_phase=0, timeout count=0, sync flops and debounced levels 0, debounce counters 0.
- Key path per key: 2-FF synchronizer → debounce counter (counts while sync≠debounced, clears otherwise; at DEBOUNCE_CYC−1 flips debounced level and clears) → press pulse = one-cycle registered rising edge of debounced level. Releases produce no pulse.
- FSM: mode press advances RUN→SET_H→SET_M→SET_S→RUN.
- RUN: on tick_1hz sec+1; sec 59→0 carries min+1; min 59→0 carries hour+1; 23:59:59→00:00:00. inc/dec ignored.
- SET_H/SET_M/SET_S: time frozen, tick_1hz does not count.
- SET_H: inc hour+1 (23→0), dec hour−1 (0→23); no carry into other fields.
- SET_M: same on min, modulo 60, no carry into hour.
- SET_S: inc or dec press clears sec to 0.
- Simultaneous inc and dec pulses: both ignored. mode with inc/dec in same cycle: mode wins, inc/dec dropped.
- Timeout: in any set state, count tick_1hz; any press (mode/inc/dec) clears count; reaching TIMEOUT_S forces RUN. Count cleared on entry to RUN.
- Blink: blink_phase toggles on tick_2hz; inc/dec press forces blink_phase=0 so edited value shows. blink_mask bit of the field selected by mode = blink_phase; other bits 0; all 0 in RUN.
- Chime: led_chime = blink_phase when mode=RUN, min=59, sec≥55; else 0.

## Timing
- All outputs registered; no combinational input→output path.
- Key latency: raw key held stable high from edge N → press pulse high during cycle N+DEBOUNCE_CYC+2 → field/mode updated at edge N+DEBOUNCE_CYC+3.
- Glitch shorter than DEBOUNCE_CYC cycles after sync: no pulse.
- tick_1hz count visible one cycle after the tick cycle.
- Mode press RUN→SET_H coincident with tick_1hz: tick applied (current state RUN). SET_S→RUN coincident with tick_1hz: tick ignored; counting resumes at next tick.
- Timeout reached coincident with a key press: press wins, count cleared, no exit.
- tick_1hz and tick_2hz coincident: both act independently same cycle.
- blink_mask and led_chime follow state/blink_phase with one cycle registration.
- Reset asserted mid-edit or mid-debounce: all state to reset values immediately; pending presses discarded.

## Test plan
- Rollover: DEBOUNCE_CYC=4; preload via set mode to 23:59:58, RUN, 2 ticks → 00:00:00, exactly one cycle after second tick.
- Set sequence: mode×1, dec×1 from hour 0 → hour 23; mode, inc×61 from min 0 → min 1, hour unchanged; mode, inc → sec 0; mode → RUN, mode=0.
- Debounce: 3-cycle glitch on key_inc in SET_H → hour unchanged; 10-cycle hold → single increment at DEBOUNCE_CYC+3 cycles after rise.
- Conflicts: inc and dec stable together in SET_M → min unchanged; mode+inc same press cycle in SET_H → mode=2, hour unchanged.
- Timeout: TIMEOUT_S=3, enter SET_H, 3 ticks no keys → mode=0; 2 ticks, inc, 2 ticks → still SET_H.
- Blink/chime: SET_M, tick_2hz pulses → blink_mask toggles 010/000; RUN at 00:59:54 → led_chime 0; 00:59:55 with blink_phase=1 → led_chime 1; async reset mid-edit → all outputs 0.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - hh:mm:ss keeper with debounced three-key set mode
//
// Purpose: owns the hour/min/sec registers and advances them on tick_1hz
// while in RUN. Three raw push-buttons (mode/inc/dec) are synchronized,
// debounced and turned into one-cycle press pulses that drive the set-mode
// FSM (RUN -> SET_H -> SET_M -> SET_S -> RUN). Set mode auto-exits after
// TIMEOUT_S idle seconds. Produces blink masks and the top-of-hour chime LED.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick_1hz   in   one-cycle enable, once per second
//   tick_2hz   in   one-cycle enable, twice per second
//   key_mode   in   raw active-high button
//   key_inc    in   raw active-high button
//   key_dec    in   raw active-high button
//   hour       out  0..23
//   min        out  0..59
//   sec        out  0..59
//   mode       out  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//   blink_mask out  [2] hour, [1] min, [0] sec blank request
//   led_chime  out  chime LED
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int TIMEOUT_S    = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic [2:0] blink_mask,
  output logic       led_chime
);

  localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} mode_t;

  mode_t state;

  // Key path, bit order: [0] mode, [1] inc, [2] dec
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2, deb, deb_d, press;
  logic [DW-1:0] db_cnt [3];

  assign raw = {key_dec, key_inc, key_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Rising edge of the debounced level only; releases make no pulse.
      press <= deb & ~deb_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            deb[i]    <= ~deb[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic press_mode, inc_ok, dec_ok, any_press, edit_press;
  assign press_mode = press[0];
  assign any_press  = |press;
  // inc and dec in the same cycle cancel; a mode press drops both.
  assign inc_ok     = press[1] & ~press[2] & ~press_mode;
  assign dec_ok     = press[2] & ~press[1] & ~press_mode;
  assign edit_press = (press[1] | press[2]) & ~press_mode;

  logic [TW-1:0] to_cnt;
  logic          blink_phase;

  assign mode = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      hour        <= '0;
      min         <= '0;
      sec         <= '0;
      to_cnt      <= '0;
      blink_phase <= 1'b0;
      blink_mask  <= '0;
      led_chime   <= 1'b0;
    end else begin
      // Edits restart the blink so the new value is shown immediately.
      if (state != RUN && edit_press) blink_phase <= 1'b0;
      else if (tick_2hz)              blink_phase <= ~blink_phase;

      // Time counts on the current state, so a RUN->SET_H press still ticks.
      if (state == RUN && tick_1hz) begin
        if (sec == 6'd59) begin
          sec <= '0;
          if (min == 6'd59) begin
            min  <= '0;
            hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end

      case (state)
        SET_H: begin
          if (inc_ok) hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          if (dec_ok) hour <= (hour == 5'd0) ? 5'd23 : hour - 5'd1;
        end
        SET_M: begin
          if (inc_ok) min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
          if (dec_ok) min <= (min == 6'd0) ? 6'd59 : min - 6'd1;
        end
        SET_S: begin
          if (inc_ok || dec_ok) sec <= '0;
        end
        default: ;
      endcase

      if (press_mode) begin
        state  <= mode_t'(state + 2'd1);
        to_cnt <= '0;
      end else if (state == RUN) begin
        to_cnt <= '0;
      end else if (any_press) begin
        to_cnt <= '0;
      end else if (tick_1hz) begin
        if (to_cnt == TW'(TIMEOUT_S - 1)) begin
          state  <= RUN;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      case (state)
        SET_H:   blink_mask <= {blink_phase, 2'b00};
        SET_M:   blink_mask <= {1'b0, blink_phase, 1'b0};
        SET_S:   blink_mask <= {2'b00, blink_phase};
        default: blink_mask <= 3'b000;
      endcase

      led_chime <= (state == RUN && min == 6'd59 && sec >= 6'd55) ? blink_phase : 1'b0;
    end
  end

endmodule
